spi_ram_arbiter: RTL and testbench

//  Memory-access controller between the SPI slave and a single-port RAM, shared with a local host port.

---
 rtl/spi_ram_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - SPI/host round-robin access controller for a single-port RAM
//
// Purpose:
//   Decodes 10-bit SPI command words (op in rx_data[DATA_W+1:DATA_W]):
//     00 load write address, 01 write data, 10 load read address, 11 read.
//   One SPI memory op can be pending at a time. It is round-robin arbitrated
//   against the local host port for a single-port RAM. Read data goes back
//   to the SPI slave (tx_*) or to the host (host_rdata/host_rvalid).
//
// Optional feature macro: SPI_ARB_OVERRUN_EN
//   When defined, adds output spi_ovr. It is a sticky flag that is set when
//   an SPI memory op arrives while another op is still pending and that
//   pending op is not being granted. Only reset clears it. When the macro is
//   undefined, such ops are dropped silently.
//
// Ports:
//   clk, rst_n      single clock, synchronous active-low reset
//   rx_data/valid   SPI command word and its 1-cycle strobe
//   tx_data/valid   SPI read data and its 1-cycle strobe
//   host_req/we/addr/wdata   host request, held until host_gnt
//   host_gnt        1-cycle pulse, coincident with the host's mem_en
//   host_rdata/rvalid        host read data and its 1-cycle strobe
//   mem_en/we/addr/wdata     RAM command, mem_en pulses once per access
//   mem_rdata       RAM read data, valid the cycle after mem_en
//   spi_ovr         (SPI_ARB_OVERRUN_EN only) sticky overrun flag

module spi_ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W+1:0]    rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
`ifdef SPI_ARB_OVERRUN_EN
  ,
  output logic                 spi_ovr
`endif
);

  // Reject configurations where the address cannot reach every RAM word.
  if (MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_cfg_check
    $error("spi_ram_arbiter: ADDR_SIZE too small for MEM_DEPTH");
  end

  localparam logic [1:0] OP_LD_WR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_LD_RD = 2'b10;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t state, state_d;

  // SPI address registers and the single-entry pending op
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 spi_pend;
  logic                 spi_pend_we;
  logic [ADDR_SIZE-1:0] spi_pend_addr;
  logic [DATA_W-1:0]    spi_pend_data;

  // Ownership of the access in flight, and the round-robin pointer
  logic owner_host;
  logic op_rd;
  logic prefer_host;

  // Next values of the registered outputs
  logic                 mem_en_d, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_d;
  logic                 host_gnt_d;
  logic                 tx_valid_d, host_rvalid_d;
  logic [DATA_W-1:0]    tx_data_d, host_rdata_d;

  logic [1:0] rx_op;
  logic       rx_is_mem_op;
  logic       arb_req;
  logic       pick_host;
  logic       spi_grant;
  logic       host_grant;
  logic       grant_rd;
  logic       rx_take_op;

  assign rx_op        = rx_data[DATA_W+1:DATA_W];
  // Ops 01 and 11 touch the RAM; 00 and 10 only load an address register.
  assign rx_is_mem_op = rx_valid & rx_op[0];

  // A lone requester always wins. When both request, the one that was
  // not granted last wins.
  assign arb_req    = (state == ST_ARB) && (spi_pend || host_req);
  assign pick_host  = host_req && (!spi_pend || prefer_host);
  assign spi_grant  = arb_req && !pick_host;
  assign host_grant = arb_req && pick_host;
  assign grant_rd   = pick_host ? !host_we : !spi_pend_we;

  // A new op can enter the pending slot if the slot is empty or is being
  // emptied by a grant on this same edge.
  assign rx_take_op = rx_is_mem_op && (!spi_pend || spi_grant);

  // State register with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_ARB;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      host_gnt    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      owner_host  <= 1'b0;
      op_rd       <= 1'b0;
      prefer_host <= 1'b0;
    end else begin
      state       <= state_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      host_gnt    <= host_gnt_d;
      tx_valid    <= tx_valid_d;
      tx_data     <= tx_data_d;
      host_rvalid <= host_rvalid_d;
      host_rdata  <= host_rdata_d;
      if (arb_req) begin
        owner_host  <= pick_host;
        op_rd       <= grant_rd;
        prefer_host <= !pick_host;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_ARB:     if (arb_req) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = op_rd ? ST_CAPTURE : ST_ARB;
      ST_CAPTURE: state_d = ST_ARB;
      default:    state_d = ST_ARB;
    endcase
  end

  // Output logic: computes the values the output registers take next edge
  always_comb begin
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    host_gnt_d    = 1'b0;
    tx_valid_d    = 1'b0;
    tx_data_d     = tx_data;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata;

    if (host_grant) begin
      mem_en_d    = 1'b1;
      mem_we_d    = host_we;
      mem_addr_d  = host_addr;
      mem_wdata_d = host_wdata;
      host_gnt_d  = 1'b1;
    end else if (spi_grant) begin
      // The granted op uses its latched address, even if an address
      // load arrives on this same edge.
      mem_en_d    = 1'b1;
      mem_we_d    = spi_pend_we;
      mem_addr_d  = spi_pend_addr;
      mem_wdata_d = spi_pend_data;
    end

    if (state == ST_CAPTURE) begin
      if (owner_host) begin
        host_rvalid_d = 1'b1;
        host_rdata_d  = mem_rdata;
      end else begin
        tx_valid_d = 1'b1;
        tx_data_d  = mem_rdata;
      end
    end
  end

  // SPI command decode and pending op slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr       <= '0;
      rd_addr       <= '0;
      spi_pend      <= 1'b0;
      spi_pend_we   <= 1'b0;
      spi_pend_addr <= '0;
      spi_pend_data <= '0;
    end else begin
      if (rx_valid && rx_op == OP_LD_WR) wr_addr <= rx_data[ADDR_SIZE-1:0];
      if (rx_valid && rx_op == OP_LD_RD) rd_addr <= rx_data[ADDR_SIZE-1:0];

      if (rx_take_op) begin
        // The address registers are sampled as they stand before this edge.
        spi_pend      <= 1'b1;
        spi_pend_we   <= (rx_op == OP_WRITE);
        spi_pend_addr <= (rx_op == OP_WRITE) ? wr_addr : rd_addr;
        spi_pend_data <= rx_data[DATA_W-1:0];
      end else if (spi_grant) begin
        spi_pend <= 1'b0;
      end
    end
  end

`ifdef SPI_ARB_OVERRUN_EN
  // Sticky overrun flag: an op arrived while the slot was full and not draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_ovr <= 1'b0;
    end else if (rx_is_mem_op && !rx_take_op) begin
      spi_ovr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - self-checking bench for spi_ram_arbiter
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef SPI_ARB_OVERRUN_EN
  logic       spi_ovr;
`endif

  spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SPI_ARB_OVERRUN_EN
    , .spi_ovr(spi_ovr)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle of read latency
  logic [7:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       gnt;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } ev_t;
  ev_t log_q[$];

  int         tx_cnt = 0, tx_cyc = -1;
  logic [7:0] tx_val = 8'h00;
  int         hrv_cnt = 0, hrv_cyc = -1;
  logic [7:0] hrv_val = 8'h00;

  always @(negedge clk) begin
    if (mem_en) log_q.push_back('{host_gnt, mem_we, mem_addr, mem_wdata, cyc});
    if (tx_valid) begin
      tx_cnt++; tx_cyc = cyc; tx_val = tx_data;
    end
    if (host_rvalid) begin
      hrv_cnt++; hrv_cyc = cyc; hrv_val = host_rdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; host_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {tx_valid, tx_data, host_gnt, host_rdata, host_rvalid,
             mem_en, mem_we, mem_addr, mem_wdata}, 64'h0);
`ifdef SPI_ARB_OVERRUN_EN
    chk({nm, "_ovr"}, spi_ovr, 0);
`endif
  endtask

  typedef struct {
    logic       is_host;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    int         en_lat;
    int         rv_lat;
  } vec_t;
  vec_t vecs[10];

  task automatic run_vec(input string nm, input vec_t v);
    int t0, n0, tx0, hrv0, got;
    n0 = log_q.size(); tx0 = tx_cnt; hrv0 = hrv_cnt;
    if (!v.is_host) begin
      rx_data = {(v.we ? 2'b00 : 2'b10), v.addr}; rx_valid = 1'b1; tick();
      rx_data = {(v.we ? 2'b01 : 2'b11), v.data}; t0 = cyc; tick();
      rx_valid = 1'b0;
    end else begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.data;
      t0 = cyc; got = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (host_gnt) begin got = 1; break; end
      end
      host_req = 1'b0;
      chk({nm, "_gnt_seen"}, got, 1);
    end
    repeat (8) tick();
    chk({nm, "_en_count"}, log_q.size(), n0 + 1);
    if (log_q.size() > n0) begin
      chk({nm, "_en_lat"}, log_q[n0].cyc - t0, v.en_lat);
      chk({nm, "_gnt"}, log_q[n0].gnt, v.is_host);
      chk({nm, "_we"}, log_q[n0].we, v.we);
      chk({nm, "_addr"}, log_q[n0].addr, v.addr);
      if (v.we) chk({nm, "_wdata"}, log_q[n0].wdata, v.data);
    end
    chk({nm, "_tx_cnt"}, tx_cnt, tx0 + ((!v.is_host && !v.we) ? 1 : 0));
    chk({nm, "_hrv_cnt"}, hrv_cnt, hrv0 + ((v.is_host && !v.we) ? 1 : 0));
    if (!v.we) begin
      if (v.is_host) begin
        chk({nm, "_rv_lat"}, hrv_cyc - t0, v.rv_lat);
        chk({nm, "_rdata"}, hrv_val, v.exp_rd);
      end else begin
        chk({nm, "_rv_lat"}, tx_cyc - t0, v.rv_lat);
        chk({nm, "_rdata"}, tx_val, v.exp_rd);
      end
    end
  endtask

  initial begin
    int n0, h0, tx0, t0, got;
    logic       e_gnt [4];
    logic       e_we  [4];
    logic [7:0] e_addr[4];
    logic [7:0] e_wd  [4];

    //        host  we    addr   data   exp_rd en rv
    vecs[0] = '{1'b0, 1'b1, 8'h05, 8'hA5, 8'h00, 2, 0};
    vecs[1] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'hA5, 2, 4};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 8'h3C, 8'h00, 1, 0};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1, 3};
    vecs[4] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h3C, 2, 4};
    vecs[5] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hA5, 1, 3};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00, 2, 0};
    vecs[7] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, 1, 3};
    vecs[8] = '{1'b1, 1'b1, 8'h00, 8'hC3, 8'h00, 1, 0};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 2, 4};

    rx_data = '0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    do_reset();
    chk_idle("reset_outputs");

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Round robin: both request together repeatedly, SPI first after reset.
    // The second SPI op arrives on the first SPI grant edge and must be kept.
    do_reset();
    n0 = log_q.size(); h0 = hrv_cnt;
    rx_data = 10'h020; rx_valid = 1'b1; tick();
    rx_data = 10'h111; tick();
    rx_data = 10'h133;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h22; tick();
    rx_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (host_gnt) begin got = 1; break; end
      tick();
    end
    chk("rr_gnt1_seen", got, 1);
    host_we = 1'b0; host_addr = 8'h30;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (host_gnt) begin got = 1; break; end
    end
    chk("rr_gnt2_seen", got, 1);
    host_req = 1'b0;
    repeat (6) tick();
    e_gnt  = '{1'b0, 1'b1, 1'b0, 1'b1};
    e_we   = '{1'b1, 1'b1, 1'b1, 1'b0};
    e_addr = '{8'h20, 8'h30, 8'h20, 8'h30};
    e_wd   = '{8'h11, 8'h22, 8'h33, 8'h00};
    chk("rr_count", log_q.size(), n0 + 4);
    if (log_q.size() >= n0 + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr%0d_gnt", k), log_q[n0+k].gnt, e_gnt[k]);
        chk($sformatf("rr%0d_we", k), log_q[n0+k].we, e_we[k]);
        chk($sformatf("rr%0d_addr", k), log_q[n0+k].addr, e_addr[k]);
        if (e_we[k]) chk($sformatf("rr%0d_wdata", k), log_q[n0+k].wdata, e_wd[k]);
      end
    end
    chk("rr_ram20", ram[8'h20], 8'h33);
    chk("rr_hrv_cnt", hrv_cnt, h0 + 1);
    chk("rr_hrdata", hrv_val, 8'h22);

    // Overrun: two SPI writes back-to-back while a host read owns the RAM
    n0 = log_q.size(); h0 = hrv_cnt;
    rx_data = 10'h040; rx_valid = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h41; tick();
    chk("ovr_host_gnt", host_gnt, 1);
    host_req = 1'b0;
    rx_data = 10'h177; tick();
    rx_data = 10'h188; tick();
    rx_data = 10'h099; tick();
    rx_valid = 1'b0;
    repeat (8) tick();
    chk("ovr_count", log_q.size(), n0 + 2);
    if (log_q.size() >= n0 + 2) begin
      chk("ovr_ev0", {log_q[n0].gnt, log_q[n0].we, log_q[n0].addr}, {1'b1, 1'b0, 8'h41});
      chk("ovr_ev1", {log_q[n0+1].gnt, log_q[n0+1].we, log_q[n0+1].addr, log_q[n0+1].wdata},
          {1'b0, 1'b1, 8'h40, 8'h77});
    end
    chk("ovr_ram40", ram[8'h40], 8'h77);
    chk("ovr_hrv_cnt", hrv_cnt, h0 + 1);
`ifdef SPI_ARB_OVERRUN_EN
    chk("ovr_flag", spi_ovr, 1);
`endif

    // Reset for one edge while an SPI read is in CAPTURE
    n0 = log_q.size(); tx0 = tx_cnt;
    rx_data = 10'h205; rx_valid = 1'b1; tick();
    rx_data = 10'h300; t0 = cyc; tick();
    rx_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk_idle("abort_outputs");
    repeat (6) tick();
    chk("abort_en_count", log_q.size(), n0 + 1);
    if (log_q.size() > n0) chk("abort_en_cyc", log_q[n0].cyc - t0, 2);
    chk("abort_no_tx", tx_cnt, tx0);
    run_vec("post_abort", vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
